piece_move_ctrl: RTL and testbench

//  Sequencer for the active falling piece on the 12x12 (144-cell) play field. Holds current piece

---
 rtl/piece_move_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_piece_move_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/piece_move_ctrl.sv
// Active-piece sequencer for a WxW play field: moves, rotation,
// gravity, hard drop, locking into the background and row clearing.
module piece_move_ctrl #(
  parameter int W  = 12,
  parameter int CW = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             spawn,
  input  logic [W*W-1:0]   spawn_sqs,
  input  logic [9:0]       spawn_center,
  input  logic             req_left,
  input  logic             req_right,
  input  logic             req_rot,
  input  logic             req_drop,
  input  logic             tick,
  input  logic [W*W-1:0]   rot_sqs,
  input  logic             rot_ok,
  output logic [W*W-1:0]   cur_sqs,
  output logic [9:0]       center,
  output logic [W*W-1:0]   bg,
  output logic             busy,
  output logic             locked,
  output logic             game_over,
  output logic [CW-1:0]    lines_cleared
);

  localparam int N  = W * W;
  localparam int PW = $clog2(W);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_ACTIVE, S_DROP,
    S_LOCK, S_CLEAR, S_OVER
  } state_t;

  function automatic logic [N-1:0] col_mask(input int c);
    logic [N-1:0] m;
    m = '0;
    for (int r = 0; r < W; r++) m[r*W+c] = 1'b1;
    return m;
  endfunction

  localparam logic [N-1:0] COL_L = col_mask(0);
  localparam logic [N-1:0] COL_R = col_mask(W-1);
  localparam logic [N-1:0] ROW_B = {{W{1'b1}}, {(N-W){1'b0}}};

  // pending bit order: 4 drop, 3 tick, 2 rot, 1 left, 0 right
  state_t          r_state;
  logic [N-1:0]    r_cur;
  logic [N-1:0]    r_bg;
  logic [9:0]      r_ctr;
  logic [4:0]      r_pend;
  logic [PW-1:0]   r_ptr;
  logic            r_locked;
  logic            r_over;
  logic [CW-1:0]   r_lines;

  logic [4:0]      w_req;
  logic [4:0]      w_clr;
  logic            w_mv_l;
  logic            w_mv_r;
  logic            w_mv_d;
  logic            w_full;
  logic [N-1:0]    w_shift;

  assign w_req  = {req_drop, tick, req_rot, req_left, req_right};
  assign w_mv_l = ~|(r_cur & COL_L) && ~|((r_cur >> 1) & r_bg);
  assign w_mv_r = ~|(r_cur & COL_R) && ~|((r_cur << 1) & r_bg);
  assign w_mv_d = ~|(r_cur & ROW_B) && ~|((r_cur << W) & r_bg);
  assign w_full = &r_bg[int'(r_ptr)*W +: W];

  always_comb begin
    w_shift = r_bg;
    for (int r = 0; r < W; r++) begin
      if (r <= int'(r_ptr)) begin
        if (r == 0) w_shift[r*W +: W] = '0;
        else        w_shift[r*W +: W] = r_bg[(r-1)*W +: W];
      end
    end
  end

  always_comb begin
    w_clr = '0;
    if (r_state == S_LOCK) begin
      w_clr = '1;
    end else if (r_state == S_ACTIVE) begin
      if      (r_pend[4]) w_clr[4] = 1'b1;
      else if (r_pend[3]) w_clr[3] = 1'b1;
      else if (r_pend[2]) w_clr[2] = 1'b1;
      else if (r_pend[1]) w_clr[1] = 1'b1;
      else if (r_pend[0]) w_clr[0] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cur    <= '0;
      r_bg     <= '0;
      r_ctr    <= '0;
      r_pend   <= '0;
      r_ptr    <= '0;
      r_locked <= 1'b0;
      r_over   <= 1'b0;
      r_lines  <= '0;
    end else begin
      r_locked <= 1'b0;
      if (r_state != S_IDLE && r_state != S_OVER)
        r_pend <= (r_pend & ~w_clr) | w_req;
      unique case (r_state)
        S_IDLE: begin
          if (spawn) begin
            r_cur   <= spawn_sqs;
            r_ctr   <= spawn_center;
            r_state <= S_SPAWN;
          end
        end
        S_SPAWN: begin
          if (|(r_cur & r_bg)) begin
            r_over  <= 1'b1;
            r_state <= S_OVER;
          end else begin
            r_state <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (r_pend[4]) begin
            r_state <= S_DROP;
          end else if (r_pend[3]) begin
            if (w_mv_d) begin
              r_cur <= r_cur << W;
              r_ctr <= r_ctr + 10'(W);
            end else begin
              r_state <= S_LOCK;
            end
          end else if (r_pend[2]) begin
            if (rot_ok) r_cur <= rot_sqs;
          end else if (r_pend[1]) begin
            if (w_mv_l) begin
              r_cur <= r_cur >> 1;
              r_ctr <= r_ctr - 10'd1;
            end
          end else if (r_pend[0]) begin
            if (w_mv_r) begin
              r_cur <= r_cur << 1;
              r_ctr <= r_ctr + 10'd1;
            end
          end
        end
        S_DROP: begin
          if (w_mv_d) begin
            r_cur <= r_cur << W;
            r_ctr <= r_ctr + 10'(W);
          end else begin
            r_state <= S_LOCK;
          end
        end
        S_LOCK: begin
          r_bg     <= r_bg | r_cur;
          r_cur    <= '0;
          r_locked <= 1'b1;
          r_ptr    <= PW'(W-1);
          r_state  <= S_CLEAR;
        end
        S_CLEAR: begin
          if (w_full) begin
            r_bg    <= w_shift;
            r_lines <= r_lines + 1'b1;
          end else if (r_ptr == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_ptr <= r_ptr - 1'b1;
          end
        end
        S_OVER: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cur_sqs       = r_cur;
  assign center        = r_ctr;
  assign bg            = r_bg;
  assign locked        = r_locked;
  assign game_over     = r_over;
  assign lines_cleared = r_lines;
  assign busy          = (r_state == S_SPAWN) || (r_state == S_DROP)
                      || (r_state == S_LOCK)  || (r_state == S_CLEAR);

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Directed bench for piece_move_ctrl: moves, rotation, drop,
// locking, row clearing and game-over.
module tb_piece_move_ctrl;

  localparam int W  = 12;
  localparam int N  = W * W;
  localparam int CW = 8;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           spawn;
  logic [N-1:0]   spawn_sqs;
  logic [9:0]     spawn_center;
  logic           req_left, req_right, req_rot, req_drop, tick;
  logic [N-1:0]   rot_sqs;
  logic           rot_ok;
  logic [N-1:0]   cur_sqs;
  logic [9:0]     center;
  logic [N-1:0]   bg;
  logic           busy, locked, game_over;
  logic [CW-1:0]  lines_cleared;

  int n_err = 0;
  int n_chk = 0;
  int lat;

  piece_move_ctrl #(.W(W), .CW(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .spawn(spawn), .spawn_sqs(spawn_sqs),
    .spawn_center(spawn_center),
    .req_left(req_left), .req_right(req_right),
    .req_rot(req_rot), .req_drop(req_drop),
    .tick(tick), .rot_sqs(rot_sqs), .rot_ok(rot_ok),
    .cur_sqs(cur_sqs), .center(center), .bg(bg),
    .busy(busy), .locked(locked),
    .game_over(game_over),
    .lines_cleared(lines_cleared)
  );

  always #5 clock = ~clock;

  function automatic logic [N-1:0] mk(input int a, b, c, d);
    logic [N-1:0] m;
    m = '0;
    m[a] = 1'b1;
    m[b] = 1'b1;
    m[c] = 1'b1;
    m[d] = 1'b1;
    return m;
  endfunction

  task automatic check(input string tag,
                       input logic [N-1:0] got,
                       input logic [N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drop_at(input int c, output int clr_lat);
    int n;
    spawn        = 1'b1;
    spawn_sqs    = mk(c, c+1, c+W, c+W+1);
    spawn_center = 10'(c+1);
    step();
    spawn = 1'b0;
    step();
    req_drop = 1'b1;
    step();
    req_drop = 1'b0;
    n = 0;
    while (!locked && n < 60) begin
      step();
      n++;
    end
    check("lock_seen", locked, 1);
    clr_lat = 0;
    while (busy && clr_lat < 60) begin
      step();
      clr_lat++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    spawn = 1'b0; spawn_sqs = '0; spawn_center = '0;
    req_left = 1'b0; req_right = 1'b0; req_rot = 1'b0;
    req_drop = 1'b0; tick = 1'b0;
    rot_sqs = '0; rot_ok = 1'b0;
    step(2);
    check("rst_cur", cur_sqs, '0);
    check("rst_bg", bg, '0);
    check("rst_busy", busy, 0);
    check("rst_over", game_over, 0);
    reset_n = 1'b1;

    // spawn square
    spawn = 1'b1;
    spawn_sqs = mk(4, 5, 16, 17);
    spawn_center = 10'd5;
    step();
    spawn = 1'b0;
    check("spawn_busy", busy, 1);
    step();
    check("active_busy", busy, 0);
    check("active_cur", cur_sqs, mk(4, 5, 16, 17));
    check("active_ctr", center, 5);

    // five lefts, last one blocked by column 0
    req_left = 1'b1;
    step(5);
    req_left = 1'b0;
    step();
    check("left_cur", cur_sqs, mk(0, 1, 12, 13));
    check("left_ctr", center, 1);
    req_left = 1'b1;
    step();
    req_left = 1'b0;
    step(2);
    check("left6_cur", cur_sqs, mk(0, 1, 12, 13));
    check("left6_ctr", center, 1);

    // right move
    req_right = 1'b1;
    step();
    req_right = 1'b0;
    step();
    check("right_cur", cur_sqs, mk(1, 2, 13, 14));
    check("right_ctr", center, 2);

    // tick > rot > left ordering
    rot_sqs = mk(14, 26, 38, 50);
    rot_ok  = 1'b1;
    req_left = 1'b1; req_rot = 1'b1; tick = 1'b1;
    step();
    req_left = 1'b0; req_rot = 1'b0; tick = 1'b0;
    step();
    check("ord_tick_cur", cur_sqs, mk(13, 14, 25, 26));
    check("ord_tick_ctr", center, 14);
    step();
    check("ord_rot_cur", cur_sqs, mk(14, 26, 38, 50));
    check("ord_rot_ctr", center, 14);
    step();
    check("ord_left_cur", cur_sqs, mk(13, 25, 37, 49));
    check("ord_left_ctr", center, 13);

    // rejected rotation
    rot_sqs = '0;
    rot_ok  = 1'b0;
    req_rot = 1'b1;
    step();
    req_rot = 1'b0;
    step(2);
    check("rot_rej_cur", cur_sqs, mk(13, 25, 37, 49));

    // fresh field, drop on empty background
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("rst2_bg", bg, '0);
    drop_at(4, lat);
    check("drop_bg", bg, mk(124, 125, 136, 137));
    check("drop_clr_lat", 32'(lat), 12);
    check("drop_lines", lines_cleared, 0);

    // stack a second square, then fill rows 10/11
    drop_at(4, lat);
    check("stack_bg", bg,
          mk(124, 125, 136, 137) | mk(100, 101, 112, 113));
    drop_at(0, lat);
    drop_at(2, lat);
    drop_at(6, lat);
    drop_at(8, lat);
    check("fill_lat", 32'(lat), 12);
    check("fill_lines", lines_cleared, 0);
    drop_at(10, lat);
    check("clr_lat", 32'(lat), 14);
    check("clr_lines", lines_cleared, 2);
    check("clr_bg", bg, mk(124, 125, 136, 137));

    // spawn into occupied cells
    spawn = 1'b1;
    spawn_sqs = mk(124, 125, 136, 137);
    spawn_center = 10'd125;
    step();
    spawn = 1'b0;
    check("ov_spawn_go", game_over, 0);
    step();
    check("ov_go", game_over, 1);
    check("ov_busy", busy, 0);
    spawn = 1'b1;
    spawn_sqs = mk(0, 1, 12, 13);
    req_left = 1'b1; tick = 1'b1;
    step(3);
    spawn = 1'b0; req_left = 1'b0; tick = 1'b0;
    step();
    check("ov_hold_cur", cur_sqs, mk(124, 125, 136, 137));
    check("ov_hold_go", game_over, 1);
    check("ov_hold_lines", lines_cleared, 2);
    #2;
    reset_n = 1'b0;
    #2;
    check("ov_rst_go", game_over, 0);
    check("ov_rst_bg", bg, '0);
    check("ov_rst_lines", lines_cleared, 0);
    reset_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
